// File: rtl/operand_entry_fsm.sv
// operand_entry_fsm: button-driven operand entry, start/result handshake and paged result display
module operand_entry_fsm #(
  parameter int DIGIT_W       = 5,
  parameter int NUM_OPERANDS  = 2,
  parameter int DIGITS_PER_OP = 2,
  parameter int RES_PAGES     = 2,
  localparam int F     = NUM_OPERANDS * DIGITS_PER_OP,
  localparam int RES_W = RES_PAGES * DIGIT_W,
  localparam int LW    = F + RES_PAGES,
  localparam int CW    = (F > 1) ? $clog2(F) : 1,
  localparam int PW    = (RES_PAGES > 1) ? $clog2(RES_PAGES) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DIGIT_W-1:0]   number,
  input  logic                 btn_change,
  input  logic                 btn_enter,
  input  logic                 btn_cancel,
  input  logic [RES_W-1:0]     result_in,
  input  logic                 result_valid,
  output logic [F*DIGIT_W-1:0] operands,
  output logic                 start,
  output logic [CW-1:0]        cursor,
  output logic [PW-1:0]        page,
  output logic [DIGIT_W-1:0]   disp_value,
  output logic [LW-1:0]        leds
);
  typedef enum logic [1:0] {S_SELECT, S_WAIT, S_RESULT} state_t;
  state_t               r_state;
  logic [F*DIGIT_W-1:0] r_ops;
  logic [RES_W-1:0]     r_result;
  logic [CW-1:0]        r_cursor;
  logic [PW-1:0]        r_page;
  logic                 r_start;
  logic [DIGIT_W-1:0]   r_disp;
  logic [LW-1:0]        r_leds;
  logic                 r_chg_q, r_ent_q, r_can_q;
  logic                 w_chg, w_ent, w_can;
  // Rising-edge detection against the previous-cycle button levels.
  assign w_can = btn_cancel & ~r_can_q;
  assign w_ent = btn_enter & ~r_ent_q;
  assign w_chg = btn_change & ~r_chg_q;
  assign operands   = r_ops;
  assign start      = r_start;
  assign cursor     = r_cursor;
  assign page       = r_page;
  assign disp_value = r_disp;
  assign leds       = r_leds;
  // Control FSM; cancel beats enter beats change, display regs lag state by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_SELECT;
      r_ops    <= '0;
      r_result <= '0;
      r_cursor <= '0;
      r_page   <= '0;
      r_start  <= 1'b0;
      r_disp   <= '0;
      r_leds   <= LW'(1);
      r_chg_q  <= 1'b1;
      r_ent_q  <= 1'b1;
      r_can_q  <= 1'b1;
    end else begin
      r_chg_q <= btn_change;
      r_ent_q <= btn_enter;
      r_can_q <= btn_cancel;
      r_start <= 1'b0;
      if (w_can) begin
        r_state  <= S_SELECT;
        r_ops    <= '0;
        r_result <= '0;
        r_cursor <= '0;
        r_page   <= '0;
      end else begin
        case (r_state)
          S_SELECT: begin
            if (w_ent) begin
              r_start <= 1'b1;
              r_state <= S_WAIT;
            end else if (w_chg) begin
              r_ops[int'(r_cursor)*DIGIT_W +: DIGIT_W] <= number;
              r_cursor <= (r_cursor == CW'(F-1)) ? '0 : r_cursor + 1'b1;
            end
          end
          S_WAIT: begin
            if (result_valid) begin
              r_result <= result_in;
              r_page   <= '0;
              r_state  <= S_RESULT;
            end
          end
          S_RESULT: begin
            if (w_ent) r_page <= (r_page == PW'(RES_PAGES-1)) ? '0 : r_page + 1'b1;
          end
          default: r_state <= S_SELECT;
        endcase
      end
      r_disp <= (r_state == S_SELECT) ? r_ops[int'(r_cursor)*DIGIT_W +: DIGIT_W] :
                (r_state == S_RESULT) ? r_result[int'(r_page)*DIGIT_W +: DIGIT_W] : '0;
      r_leds <= (r_state == S_SELECT) ? LW'(1) << r_cursor :
                (r_state == S_RESULT) ? LW'(1) << (F + int'(r_page)) : '0;
    end
  end
endmodule

// File: doc/operand_entry_fsm.md
OPERAND_ENTRY_FSM -- requirements
Module: operand_entry_fsm

Interface
REQ-001 Parameter DIGIT_W, default 5: width of one entry field and of the number switch input.
REQ-002 Parameter NUM_OPERANDS, default 2, legal range 1..4: number of operands entered.
REQ-003 Parameter DIGITS_PER_OP, default 2, legal range 1..4: fields per operand.
REQ-004 Parameter RES_PAGES, default 2, legal range 1..4: display pages of the result.
REQ-005 Derived values: F = NUM_OPERANDS*DIGITS_PER_OP; RES_W = RES_PAGES*DIGIT_W; CW = max(1, clog2(F)); PW = max(1, clog2(RES_PAGES)).
REQ-006 Port list:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- number  in  DIGIT_W  switch value to be written into the current field.
- btn_change  in  1  level, already synchronous to clk.
- btn_enter  in  1  level, already synchronous to clk.
- btn_cancel  in  1  level, already synchronous to clk.
- result_in  in  RES_W  result from the external operation unit.
- result_valid  in  1  qualifies result_in.
- operands  out  F*DIGIT_W  all fields concatenated.
- start  out  1  one-cycle request to the operation unit.
- cursor  out  CW  current field index.
- page  out  PW  current result page.
- disp_value  out  DIGIT_W  value currently shown.
- leds  out  F+RES_PAGES  one-hot position indicator.

Function
REQ-007 Each button SHALL be registered every cycle; an event SHALL be a rising edge (current=1, previous=0), acted on in the cycle it is detected.
REQ-008 When several events occur in one cycle, only one SHALL act, with priority cancel > enter > change.
REQ-009 States SHALL be SELECT, WAIT and RESULT.
REQ-010 Field k SHALL occupy operands[k*DIGIT_W +: DIGIT_W]. Field k = i*DIGITS_PER_OP + j is digit j (0 = least significant) of operand i.
REQ-011 SELECT + change SHALL write number into field cursor and advance cursor by 1, wrapping from F-1 to 0. The write and the advance take effect in the same edge.
REQ-012 SELECT + enter SHALL assert start for exactly one cycle and go to WAIT. Operands SHALL be held stable from that point until the FSM returns to SELECT.
REQ-013 WAIT + result_valid SHALL capture result_in into the result register, set page=0 and go to RESULT. result_valid SHALL be ignored in every other state.
REQ-014 WAIT SHALL ignore change and enter.
REQ-015 RESULT + enter SHALL advance page by 1, wrapping from RES_PAGES-1 to 0.
REQ-016 RESULT SHALL ignore change.
REQ-017 Cancel in any state SHALL, on the next edge:
- clear all operands to 0;
- set cursor=0 and page=0;
- clear the result register;
- go to SELECT.
start SHALL not be asserted. Cancel during WAIT aborts the request; a later result_valid is ignored.
REQ-018 disp_value SHALL be registered and track the state with one cycle of latency:
- SELECT: field[cursor].
- WAIT: 0.
- RESULT: result[page*DIGIT_W +: DIGIT_W], page 0 least significant.
REQ-019 leds SHALL be registered with the same one-cycle latency:
- SELECT: bit cursor set.
- WAIT: all zero.
- RESULT: bit F+page set.
Exactly one bit SHALL be set outside WAIT.
REQ-020 All outputs SHALL be driven from registers; no combinational path from any input to any output.

Reset
REQ-021 While rst_n=0, asynchronously:
- state=SELECT;
- operands=0, result register=0;
- cursor=0, page=0, start=0;
- disp_value=0, leds=1 (bit 0).
REQ-022 Button history registers SHALL reset to 1, so a button held through reset release generates no event until it is released and pressed again.
REQ-023 Reset asserted mid-operation, including in WAIT, SHALL override everything; result_valid arriving after release SHALL be ignored.

Verification (defaults: F=4, RES_W=10, leds width 6)
REQ-024 Entry and wrap:
- Stimulus: number=5'h03 then change; number=5'h11 then change; change twice more.
- Response: fields 0 and 1 = 03 and 11; fields 2 and 3 = 11; cursor wraps to 0; leds=6'b000001.
REQ-025 Handshake:
- Stimulus: enter; result_valid=1 with result_in=10'h2A5 three cycles later.
- Response: start high exactly one cycle; leds=0 during WAIT; then RESULT with page 0, disp_value=5'h05, leds=6'b010000.
REQ-026 Paging:
- Stimulus: in RESULT, enter, then enter again.
- Response: page 1, disp_value=5'h15, leds=6'b100000; then page 0 again. change has no effect.
REQ-027 Priority:
- Stimulus 1: change and enter rising in the same cycle in SELECT.
- Response 1: only enter acts; no field is written.
- Stimulus 2: cancel and enter rising together.
- Response 2: SELECT, operands=0, start never asserted.
REQ-028 Abort:
- Stimulus: cancel in WAIT, then result_valid=1 two cycles later.
- Response: SELECT, result register stays 0, disp_value=field 0.
REQ-029 Reset:
- Stimulus: rst_n low in RESULT; release with btn_enter held high.
- Response: all reset values hold; no page or state change until enter is released and pressed again.
